uart_rx: RTL and testbench

UART receiver for the display controller: recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop) from an asynchronous serial line. It samples each bit at its midpoint using a counter clocked at `divisor` cycles per bit, and presents each byte with a one-cycle `valid` strobe. It is the receive-side counterpart of `uart_tx`, with the same `divisor` semantics, so a `uart_tx` output can drive it directly.

---
 rtl/uart_sync.sv | 24 ++
 rtl/uart_rx.sv | 128 ++++++++++++
 tb/tb_uart_rx.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/uart_sync.sv
// Two-flop synchronizer for a single asynchronous input; both flops reset to rst_val.
// Latency: 2 cycles from d to q. No backpressure; it samples d every cycle.
module uart_sync #(
    parameter logic rst_val = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= rst_val;
            q    <= rst_val;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: samples each bit at its midpoint and strobes each byte out.
// Latency: valid/frame_error in the cycle after the stop-sample edge (E0 + 2 + divisor/2 + 9*divisor).
// Backpressure: none; a missed valid loses the byte, and data holds until the next valid.
module uart_rx #(
    parameter int divisor = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxi,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_error
);

    localparam int CW = $clog2(divisor);
    localparam logic [CW-1:0] CNT_BIT  = CW'(divisor - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(divisor / 2 - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    if (divisor < 4 || (divisor % 2) != 0) begin : g_bad_divisor
        $error("uart_rx: divisor must be even and >= 4");
    end

    logic          rx_s;
    logic [2:0]    state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [7:0]    shreg, shreg_nx;
    logic [2:0]    bidx, bidx_nx;
    logic [7:0]    data_nx;
    logic          valid_nx, fe_nx;
    logic          tick;

    uart_sync #(.rst_val(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxi),
        .q   (rx_s)
    );

    assign tick = (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            shreg       <= '0;
            bidx        <= '0;
            data        <= '0;
            valid       <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            shreg       <= shreg_nx;
            bidx        <= bidx_nx;
            data        <= data_nx;
            valid       <= valid_nx;
            frame_error <= fe_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = tick ? CNT_BIT : cnt - CW'(1);
        shreg_nx = shreg;
        bidx_nx  = bidx;
        data_nx  = data;
        valid_nx = 1'b0;
        fe_nx    = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_nx = cnt;
                // Half-bit load puts every later tick at a bit midpoint.
                if (!rx_s) begin
                    state_nx = S_START;
                    cnt_nx   = CNT_HALF;
                end
            end
            S_START: begin
                if (tick) begin
                    if (rx_s) begin
                        state_nx = S_IDLE;
                    end else begin
                        state_nx = S_DATA;
                        bidx_nx  = '0;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    shreg_nx = {rx_s, shreg[7:1]};
                    bidx_nx  = bidx + 3'd1;
                    if (bidx == 3'd7) begin
                        state_nx = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (rx_s) begin
                        data_nx  = shreg;
                        valid_nx = 1'b1;
                        state_nx = S_IDLE;
                    end else begin
                        fe_nx    = 1'b1;
                        state_nx = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // A held-low line must not be read as a string of frames.
                cnt_nx = cnt;
                if (rx_s) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at divisor 32 and divisor 4.
module tb_uart_rx;

    typedef struct {
        bit         fe;
        logic [7:0] d;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxi0 = 1'b1;
    logic       rxi1 = 1'b1;
    logic [7:0] data0, data1;
    logic       valid0, valid1, fe0, fe1;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t m0_e, m1_e;

    uart_rx #(.divisor(32)) u0 (
        .clk         (clk),
        .rst         (rst),
        .rxi         (rxi0),
        .data        (data0),
        .valid       (valid0),
        .frame_error (fe0)
    );

    uart_rx #(.divisor(4)) u1 (
        .clk         (clk),
        .rst         (rst),
        .rxi         (rxi1),
        .data        (data1),
        .valid       (valid1),
        .frame_error (fe1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input longint act, input longint expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, expv, expv);
        end
    endfunction

    task automatic setl(input int ln, input logic v);
        if (ln == 0) rxi0 = v;
        else         rxi1 = v;
    endtask

    // Called right after a negedge; drives one full 8N1 frame.
    task automatic send(input int ln, input logic [7:0] b, input bit stopb, input int div, input bit push);
        exp_t e;
        if (push) begin
            e.fe  = !stopb;
            e.d   = b;
            e.cyc = -1;
            if (ln == 0) q0.push_back(e);
            else         q1.push_back(e);
        end
        setl(ln, 1'b0);
        repeat (div) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            setl(ln, b[i]);
            repeat (div) @(negedge clk);
        end
        setl(ln, stopb);
        repeat (div) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (valid0 && fe0) begin
                chk("both_strobes0", 1, 0);
            end else if (valid0 || fe0) begin
                if (q0.size() == 0) begin
                    chk("unexpected_strobe0", {fe0, valid0}, 0);
                end else begin
                    m0_e = q0.pop_front();
                    chk("kind0", fe0, m0_e.fe);
                    if (!m0_e.fe) chk("data0", data0, m0_e.d);
                    if (m0_e.cyc >= 0) chk("latency0", cyc, m0_e.cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (valid1 && fe1) begin
                chk("both_strobes1", 1, 0);
            end else if (valid1 || fe1) begin
                if (q1.size() == 0) begin
                    chk("unexpected_strobe1", {fe1, valid1}, 0);
                end else begin
                    m1_e = q1.pop_front();
                    chk("kind1", fe1, m1_e.fe);
                    if (!m1_e.fe) chk("data1", data1, m1_e.d);
                end
            end
        end
    end

    initial begin
        exp_t e;
        logic [7:0] b;

        repeat (4) @(negedge clk);
        chk("rst_data0", data0, 0);
        chk("rst_valid0", valid0, 0);
        chk("rst_fe0", fe0, 0);
        chk("rst_data1", data1, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Exact latency: E0 is the next posedge, valid expected after edge E0+306.
        e.fe  = 1'b0;
        e.d   = 8'hA5;
        e.cyc = cyc + 1 + 306;
        q0.push_back(e);
        send(0, 8'hA5, 1'b1, 32, 1'b0);
        repeat (20) @(negedge clk);

        // Back-to-back frames at divisor 32.
        for (int j = 0; j < 16; j++) begin
            b = 8'(j * 17);
            send(0, b, 1'b1, 32, 1'b1);
        end
        repeat (20) @(negedge clk);

        // Glitch shorter than half a bit.
        setl(0, 1'b0);
        repeat (10) @(negedge clk);
        setl(0, 1'b1);
        repeat (40) @(negedge clk);
        chk("glitch_idle", u0.state, 0);
        send(0, 8'h3C, 1'b1, 32, 1'b1);
        repeat (20) @(negedge clk);

        // Framing error followed by a held-low line.
        send(0, 8'h55, 1'b0, 32, 1'b1);
        repeat (100) @(negedge clk);
        chk("fe_data_hold", data0, 8'h3C);
        setl(0, 1'b1);
        repeat (20) @(negedge clk);
        send(0, 8'h81, 1'b1, 32, 1'b1);
        repeat (20) @(negedge clk);

        // Reset during data bit 4 of 0xFF.
        setl(0, 1'b0);
        repeat (32) @(negedge clk);
        setl(0, 1'b1);
        repeat (4 * 32 + 8) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_data", data0, 0);
        chk("mid_rst_valid", valid0, 0);
        chk("mid_rst_fe", fe0, 0);
        chk("mid_rst_state", u0.state, 0);
        repeat (40) @(negedge clk);
        send(0, 8'h12, 1'b1, 32, 1'b1);
        repeat (20) @(negedge clk);

        // Divisor 4: edge bytes then a full back-to-back sweep.
        send(1, 8'h00, 1'b1, 4, 1'b1);
        send(1, 8'hFF, 1'b1, 4, 1'b1);
        send(1, 8'h5A, 1'b1, 4, 1'b1);
        for (int j = 0; j < 256; j++) begin
            send(1, 8'(j), 1'b1, 4, 1'b1);
        end
        repeat (20) @(negedge clk);
        chk("data1_last", data1, 8'hFF);

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
